// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, data-bit-count codes and frame-format helpers
// used by the UART transmit channel and its FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] databits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    // Keeps only the bits that are actually serialised for a given data-bit code.
    function automatic logic [7:0] dataMask(input logic [1:0] code);
        logic [7:0] mask;
        case (code)
            DBITS_5: mask = 8'h1F;
            DBITS_6: mask = 8'h3F;
            DBITS_7: mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO holding host bytes until the framer pops them.
// Full/empty come from the registered occupancy count, so a push is never enabled by a same-cycle pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rdPtr];
    assign full    = (r_count == DEPTH_C);
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule

// File: rtl/uart_tx_ch.sv
// uart_tx_ch: UART transmit channel with baud tick generator, TX FIFO, framing FSM and CTS/RTS.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK (line-low) state.
module uart_tx_ch
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DVSR_W     = 11,
    parameter int OVERSAMPLE = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DVSR_W-1:0]             dvsr,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          cts_n,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          rts_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MARGIN_C  = CW'(RTS_MARGIN);

    tx_state_e        r_state;
    tx_state_e        w_stateNext;

    logic [DVSR_W-1:0] r_baudCnt;
    logic [DVSR_W-1:0] r_dvsrCur;
    logic [TW-1:0]     r_tickCnt;
    logic [2:0]        r_bitCnt;
    logic [7:0]        r_shift;
    logic              r_parityBit;
    logic [1:0]        r_dbCode;
    logic              r_twoStop;
    logic              r_parityEn;
    logic              r_breakStop;
    logic              r_tx;
    logic              r_txDone;
    logic              r_rtsN;

    logic              w_tick;
    logic              w_bitEnd;
    logic [2:0]        w_lastData;
    logic              w_tx;
    logic              w_done;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_breakReq;
    logic [7:0]        w_head;
    logic [7:0]        w_headMasked;
    logic [CW-1:0]     w_count;

`ifdef UART_TX_BREAK_EN
    assign w_breakReq = break_req;
`else
    assign w_breakReq = 1'b0;
`endif

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid),
        .wr_data (wr_data),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // The divisor is re-sampled only at wrap so a mid-period change never overshoots the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baudCnt <= '0;
            r_dvsrCur <= dvsr;
        end else if (w_tick) begin
            r_baudCnt <= '0;
            r_dvsrCur <= dvsr;
        end else begin
            r_baudCnt <= r_baudCnt + DVSR_W'(1);
        end
    end

    assign w_tick       = (r_baudCnt == r_dvsrCur);
    assign w_bitEnd     = w_tick && (r_tickCnt == TICK_LAST);
    assign w_lastData   = 3'(databits(r_dbCode) - 4'd1);
    assign w_headMasked = w_head & dataMask(data_bit_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tickCnt   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parityBit <= 1'b0;
            r_dbCode    <= DBITS_8;
            r_twoStop   <= 1'b0;
            r_parityEn  <= 1'b0;
            r_breakStop <= 1'b0;
            r_tx        <= 1'b1;
            r_txDone    <= 1'b0;
            r_rtsN      <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_tx     <= w_tx;
            r_txDone <= w_done;
            r_rtsN   <= ((DEPTH_C - w_count) < MARGIN_C);

            if (w_pop) begin
                r_shift     <= w_headMasked;
                r_parityBit <= (^w_headMasked) ^ parity_type;
                r_dbCode    <= data_bit_num;
                r_twoStop   <= stop_bit_num;
                r_parityEn  <= parity_en;
                r_breakStop <= 1'b0;
            end

            // Mark-after-break reuses STOP for exactly one bit time and must not signal a frame end.
            if (r_state == BREAK) begin
                r_twoStop   <= 1'b0;
                r_breakStop <= 1'b1;
            end

            if (w_stateNext != r_state) begin
                r_tickCnt <= '0;
                r_bitCnt  <= '0;
            end else if (w_bitEnd) begin
                r_tickCnt <= '0;
                r_bitCnt  <= r_bitCnt + 3'd1;
                if (r_state == DATA) begin
                    r_shift <= r_shift >> 1;
                end
            end else if (w_tick) begin
                r_tickCnt <= r_tickCnt + TW'(1);
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_breakReq) begin
                    w_stateNext = BREAK;
                end else if (!w_empty && !cts_n) begin
                    w_stateNext = START;
                end
            end
            START: begin
                if (w_bitEnd) begin
                    w_stateNext = DATA;
                end
            end
            DATA: begin
                if (w_bitEnd && (r_bitCnt == w_lastData)) begin
                    w_stateNext = r_parityEn ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bitEnd) begin
                    w_stateNext = STOP;
                end
            end
            STOP: begin
                if (w_bitEnd && (r_bitCnt == {2'b00, r_twoStop})) begin
                    w_stateNext = IDLE;
                end
            end
            BREAK: begin
                if (!w_breakReq) begin
                    w_stateNext = STOP;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Line level and strobes for the current state; the line level is registered before the pad.
    always_comb begin
        w_tx   = 1'b1;
        w_done = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:    w_pop  = !w_breakReq && !w_empty && !cts_n;
            START:   w_tx   = 1'b0;
            DATA:    w_tx   = r_shift[0];
            PARITY:  w_tx   = r_parityBit;
            STOP:    w_done = (w_stateNext == IDLE) && !r_breakStop;
            BREAK:   w_tx   = 1'b0;
            default: w_tx   = 1'b1;
        endcase
    end

    assign wr_ready   = !w_full;
    assign tx         = r_tx;
    assign tx_busy    = (r_state != IDLE);
    assign tx_done    = r_txDone;
    assign rts_n      = r_rtsN;
    assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_tx_ch.sv
// tb_uart_tx_ch: directed stimulus for uart_tx_ch with a frame scoreboard; a monitor decodes each
// serial frame at mid-bit and compares it with the expected frame queued when the byte was written.
module tb_uart_tx_ch;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [10:0] dvsr;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num;
    logic        parity_en;
    logic        parity_type;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        cts_n;
    logic        break_req;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic        rts_n;
    logic [4:0]  fifo_count;

    int     checks     = 0;
    int     failures   = 0;
    int     framesSeen = 0;
    int     bitClk     = 64;
    logic   monitorEn  = 1'b1;
    frame_t expQ[$];

    uart_tx_ch #(
        .FIFO_DEPTH (16),
        .DVSR_W     (11),
        .OVERSAMPLE (16),
        .RTS_MARGIN (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dvsr         (dvsr),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .cts_n        (cts_n),
`ifdef UART_TX_BREAK_EN
        .break_req    (break_req),
`endif
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .rts_n        (rts_n),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Queue the expected frame (len 0 = no frame expected) and hand one byte to the DUT.
    task automatic applyStimulus(input logic [7:0] data, input logic [11:0] expBits, input int expLen);
        int guard = 0;
        if (expLen > 0) begin
            expQ.push_back('{bits: expBits, len: expLen});
        end
        @(negedge clk);
        while (!wr_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b1;
        wr_data  = data;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (framesSeen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frames_done", 32'(framesSeen), 32'(target));
    endtask

    // Frame monitor: start bit detected on a falling line, every bit sampled at its centre.
    initial begin : monitorProc
        logic        prevTx;
        logic [11:0] got;
        frame_t      exp;
        int          elapsed;
        int          guard;
        int          bc;
        prevTx = 1'b1;
        forever begin
            @(negedge clk);
            if (monitorEn && prevTx && !tx) begin
                bc  = bitClk;
                got = '0;
                repeat (bc / 2) @(negedge clk);
                elapsed = bc / 2;
                got[0]  = tx;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame actual=frame expected=none");
                    exp.bits = '0;
                    exp.len  = 10;
                end else begin
                    exp = expQ.pop_front();
                end
                for (int k = 1; k < exp.len; k++) begin
                    repeat (bc) @(negedge clk);
                    elapsed += bc;
                    got[k] = tx;
                end
                checkOutput("frame_bits", 32'(got), 32'(exp.bits));
                guard = 0;
                while (!tx_done && guard < 2 * bc) begin
                    @(negedge clk);
                    elapsed++;
                    guard++;
                end
                checkOutput("done_seen", 32'(tx_done), 32'd1);
                checkRange("done_timing", elapsed + 1, exp.len * bc - 4, exp.len * bc + 4);
                @(negedge clk);
                checkOutput("done_width", 32'(tx_done), 32'd0);
                framesSeen++;
            end
            prevTx = tx;
        end
    end

    initial begin : watchdog
        #(800_000);
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulusProc
        int   accepted;
        int   guard;
        int   base;
        int   gap;
        logic seenDone;
        logic seenLow;
        int   highCount;

        rst          = 1'b1;
        dvsr         = 11'd3;
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = 8'h00;
        cts_n        = 1'b0;
        break_req    = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_tx",         32'(tx),         32'd1);
        checkOutput("rst_tx_busy",    32'(tx_busy),    32'd0);
        checkOutput("rst_tx_done",    32'(tx_done),    32'd0);
        checkOutput("rst_wr_ready",   32'(wr_ready),   32'd1);
        checkOutput("rst_rts_n",      32'(rts_n),      32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] 8N1 frame 0xA5");
        applyStimulus(8'hA5, 12'h34A, 10);
        waitFrames(1, 1500);
        checkOutput("8n1_fifo_empty", 32'(fifo_count), 32'd0);

        $display("[TB] 7O2 frame 0x83");
        data_bit_num = 2'b10;
        parity_en    = 1'b1;
        parity_type  = 1'b1;
        stop_bit_num = 1'b1;
        applyStimulus(8'h83, 12'h706, 11);
        waitFrames(2, 1500);

        $display("[TB] 5E1 frame 0xF3");
        data_bit_num = 2'b00;
        parity_en    = 1'b1;
        parity_type  = 1'b0;
        stop_bit_num = 1'b0;
        applyStimulus(8'hF3, 12'h0E6, 8);
        waitFrames(3, 1500);

        $display("[TB] dvsr=0 8N1 frame 0x96");
        data_bit_num = 2'b11;
        parity_en    = 1'b0;
        dvsr         = 11'd0;
        bitClk       = 16;
        repeat (8) @(negedge clk);
        applyStimulus(8'h96, 12'h32C, 10);
        waitFrames(4, 600);
        dvsr   = 11'd3;
        bitClk = 64;
        repeat (8) @(negedge clk);

        $display("[TB] full FIFO with cts_n high");
        cts_n    = 1'b1;
        accepted = 0;
        base     = framesSeen;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
            if (wr_ready) begin
                accepted++;
            end
            if (i < 16) begin
                expQ.push_back('{bits: {3'b000, 1'b1, 8'h10 + 8'(i), 1'b0}, len: 10});
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("full_accepted",  32'(accepted),   32'd16);
        checkOutput("full_wr_ready",  32'(wr_ready),   32'd0);
        checkOutput("full_count",     32'(fifo_count), 32'd16);
        checkOutput("full_rts_n",     32'(rts_n),      32'd1);
        checkOutput("full_tx_idle",   32'(tx),         32'd1);
        checkOutput("full_busy",      32'(tx_busy),    32'd0);

        $display("[TB] flow control");
        cts_n = 1'b0;
        guard = 0;
        while (fifo_count != 5'd13 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("flow_third_pop", 32'(fifo_count), 32'd13);
        repeat (100) @(negedge clk);
        cts_n = 1'b1;
        waitFrames(base + 3, 1500);
        repeat (800) @(negedge clk);
        checkOutput("hold_busy",  32'(tx_busy),    32'd0);
        checkOutput("hold_tx",    32'(tx),         32'd1);
        checkOutput("hold_count", 32'(fifo_count), 32'd13);
        checkOutput("hold_rts_n", 32'(rts_n),      32'd0);
        cts_n = 1'b0;
        waitFrames(base + 16, 13 * 700 + 1000);
        repeat (4) @(negedge clk);
        checkOutput("drain_count",    32'(fifo_count), 32'd0);
        checkOutput("drain_wr_ready", 32'(wr_ready),   32'd1);
        checkOutput("drain_rts_n",    32'(rts_n),      32'd0);

        $display("[TB] reset mid-frame");
        monitorEn = 1'b0;
        applyStimulus(8'h55, 12'h000, 0);
        applyStimulus(8'h66, 12'h000, 0);
        guard = 0;
        while (!tx_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_tx",    32'(tx),         32'd1);
        checkOutput("midrst_count", 32'(fifo_count), 32'd0);
        checkOutput("midrst_busy",  32'(tx_busy),    32'd0);
        seenDone = 1'b0;
        seenLow  = 1'b0;
        repeat (800) begin
            @(negedge clk);
            seenDone |= tx_done;
            seenLow  |= !tx;
        end
        checkOutput("midrst_no_done",  32'(seenDone), 32'd0);
        checkOutput("midrst_no_frame", 32'(seenLow),  32'd0);

`ifdef UART_TX_BREAK_EN
        $display("[TB] break");
        cts_n = 1'b1;
        applyStimulus(8'hC3, 12'h000, 0);
        break_req = 1'b1;
        repeat (2) @(negedge clk);
        highCount = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx) begin
                highCount++;
            end
        end
        checkOutput("break_tx_low", 32'(highCount),  32'd0);
        checkOutput("break_no_pop", 32'(fifo_count), 32'd1);
        cts_n = 1'b0;
        repeat (4) @(negedge clk);
        base = framesSeen;
        expQ.push_back('{bits: 12'h386, len: 10});
        monitorEn = 1'b1;
        break_req = 1'b0;
        guard = 0;
        while (!tx && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        gap      = 0;
        seenDone = 1'b0;
        while (tx && gap < 200) begin
            @(negedge clk);
            gap++;
            seenDone |= tx_done;
        end
        checkRange("mark_after_break", gap, 60, 68);
        checkOutput("mark_no_done", 32'(seenDone), 32'd0);
        waitFrames(base + 1, 1500);
`endif

        monitorEn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ch.md
Name: uart_tx_ch

Overview:
- Parametrised next-generation UART transmit channel: integrated baud tick generator, TX FIFO, framing FSM and CTS/RTS flow control in one block.
- The host pushes bytes through a valid/ready interface. The block serialises them LSB-first with a configurable frame (5–8 data bits, optional even/odd parity, 1 or 2 stop bits).
- Sits between the bus-side register block and the pad; one instance per UART channel.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, ≥2.
- DVSR_W, 11, width of the baud divisor.
- OVERSAMPLE, 16, baud ticks per serial bit.
- RTS_MARGIN, 2, free FIFO entries below which rts_n deasserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clocks.
- data_bit_num  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- stop_bit_num  in  1  0=1 stop bit, 1=2 stop bits.
- parity_en  in  1  parity bit inserted when 1.
- parity_type  in  1  0=even, 1=odd.
- wr_valid  in  1  host byte valid.
- wr_data  in  8  host byte; bits above the data-bit count are ignored.
- wr_ready  out  1  FIFO can accept a byte.
- cts_n  in  1  remote clear-to-send, active-low.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress (FSM not IDLE).
- tx_done  out  1  one-cycle pulse at end of final stop bit.
- rts_n  out  1  low while free FIFO entries ≥ RTS_MARGIN.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0, wr_ready=1, rts_n=0, fifo_count=0. The FIFO is emptied and the baud counter cleared.
- Baud counter:
  - Free-running, counts 0..dvsr, tick=1 in the cycle count==dvsr.
  - dvsr=0 gives a tick every cycle.
  - A dvsr change takes effect at the next wrap.
- Write handshake:
  - Byte accepted on the clk edge where wr_valid & wr_ready; fifo_count updates the next cycle.
  - wr_ready = !full, registered view. No combinational dependency on a same-cycle pop, so a full FIFO rejects a write even if a pop occurs that cycle.
- FSM states:
  - IDLE: if !empty & !cts_n, pop the head byte, latch the config fields (data bits, stop bits, parity_en, parity_type) and go to START. Config changes mid-frame are ignored.
  - START: tx=0 for OVERSAMPLE ticks. The tick count restarts on entry, so the first bit lasts OVERSAMPLE to OVERSAMPLE+1 tick periods.
  - DATA: shift LSB first, OVERSAMPLE ticks per bit, for N=5..8 bits.
  - PARITY (only if parity_en): tx = XOR of the N data bits, inverted when parity_type=1.
  - STOP: tx=1 for 1 or 2 bit times. On the last tick, pulse tx_done and return to IDLE.
- tx is a registered output (no glitches).
- Back-to-back frames: minimum IDLE dwell is 1 clock between frames.
- cts_n is sampled only in IDLE. Deassertion mid-frame does not abort the frame; the next frame is held off.
- Empty FIFO with write and IDLE in the same cycle: the byte is popped the following cycle.
- rts_n = !((FIFO_DEPTH - fifo_count) ≥ RTS_MARGIN), registered.
- Reset mid-frame: tx=1 the next cycle, FIFO contents discarded, no tx_done.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro defined:
  - Adds input break_req (1 bit).
  - When asserted in IDLE, the FSM enters BREAK: tx=0 and no pop while break_req=1.
  - On deassertion, enters STOP for one bit time (mark-after-break), no tx_done pulse, then returns to IDLE.
  - break_req asserted mid-frame is deferred until IDLE.
- Without the macro: no break_req port and no BREAK state.

Decomposition:
- Package uart_pkg:
  - State enum tx_state_e {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - data_bit_num encoding constants.
  - Function databits(code) → 5..8.
- Sub-module: uart_sync_fifo (DEPTH, WIDTH=8; push/pop/full/empty/count). Instantiated once.
- Baud counter and framing FSM live in uart_tx_ch.

Test Plan:
- 8N1 frame: dvsr=3, OVERSAMPLE=16, 8N1, write 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 64 clocks. tx_done pulses 640±4 clocks after the pop; fifo_count returns to 0.
- 7O2 frame: data_bit_num=10, parity_en=1, parity_type=1, stop=1, write 0x83 → tx = start 0, data 1,1,0,0,0,0,0, parity 1, stop 1,1. Bit 7 is ignored. 11 bit times.
- Full FIFO: FIFO_DEPTH=16, cts_n=1, write 17 bytes → wr_ready low after 16 accepts; fifo_count=16; rts_n=1 once free entries <2; tx stays 1.
- Flow control: release cts_n=0 → frames start; raise cts_n mid-frame 3 → frame 3 completes and frame 4 is held until cts_n=0.
- Reset mid-frame: assert rst during DATA → next cycle tx=1, fifo_count=0, tx_busy=0, no tx_done.
- Break (with UART_TX_BREAK_EN): break_req high 200 clocks in IDLE → tx=0 throughout, then tx=1 for 64 clocks before the next queued frame starts.
